waveform_generator: RTL and testbench

Parametrised, multi-mode successor to the team's triangle counter. It produces a registered N-bit waveform (triangle, sawtooth up, sawtooth down or square) between runtime-programmable bounds `lo`/`hi`, with a programmable step. It never overshoots a bound or wraps modulo 2^N. It sits between the control registers and the PWM/DAC drive logic and advances only on `ena`.

---
 rtl/wavegen_pkg.sv | 23 ++
 rtl/bounded_stepper.sv | 39 +++
 rtl/waveform_generator.sv | 192 +++++++++++++++++++
 tb/tb_waveform_generator.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/wavegen_pkg.sv
// Shared types and constants for the waveform generator and its stepper.
package wavegen_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    M_TRIANGLE = 2'd0,
    M_SAW_UP   = 2'd1,
    M_SAW_DOWN = 2'd2,
    M_SQUARE   = 2'd3
  } wave_mode_t;

  typedef enum logic {
    S_DOWN = 1'b0,
    S_UP   = 1'b1
  } dir_state_t;

  // Direction a mode starts in when (re)loading its start value.
  function automatic dir_state_t start_dir(input wave_mode_t m);
    return (m == M_SAW_DOWN) ? S_DOWN : S_UP;
  endfunction

endpackage

// File: rtl/bounded_stepper.sv
// Combinational step toward a bound, computed in N+1 bits so the add and
// the subtract can never wrap. hit_bound means the step would pass beyond
// the bound; next_value is then clamped to that bound. When the step lands
// exactly on the bound, hit_bound stays low and next_value equals the bound.
module bounded_stepper #(
  parameter int N = 8
) (
  input  logic [N-1:0] value,
  input  logic [N-1:0] step,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic         direction,
  output logic [N-1:0] next_value,
  output logic         hit_bound
);

  logic [N:0] sum;
  logic [N:0] lo_plus_step;

  assign sum          = {1'b0, value} + {1'b0, step};
  assign lo_plus_step = {1'b0, lo} + {1'b0, step};

  // Pick the add or subtract path and clamp to the bound it would pass.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    next_value = value;
    hit_bound  = 1'b0;
    if (direction) begin
      hit_bound  = sum > {1'b0, hi};
      next_value = hit_bound ? hi : sum[N-1:0];
    end else begin
      // value < lo + step is the same test as value - step < lo, without
      // ever forming a negative difference.
      hit_bound  = {1'b0, value} < lo_plus_step;
      next_value = hit_bound ? lo : (value - step);
    end
  end

endmodule

// File: rtl/waveform_generator.sv
// Multi-mode bounded waveform generator (triangle, saw up, saw down, square).
// Optional build macro: WAVEGEN_PRESCALE_EN - when defined, only every DIV-th
// enabled cycle is an update; otherwise every enabled cycle is an update.
module waveform_generator
  import wavegen_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [MODE_W-1:0] mode,
  input  logic [N-1:0]      lo,
  input  logic [N-1:0]      hi,
  input  logic [N-1:0]      step,
  output logic [N-1:0]      out,
  output logic              dir,
  output logic              cycle_done
);

  if (DIV < 1) begin : g_div_invalid
    $error("waveform_generator: DIV must be at least 1");
  end

  wave_mode_t mode_in;
  assign mode_in = wave_mode_t'(mode);

  logic update;

`ifdef WAVEGEN_PRESCALE_EN
  localparam int                PRESC_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0] presc_q;

  assign update = ena && (presc_q == PRESC_TC);

  // Count enabled cycles; wrap at terminal count, hold while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else if (ena) begin
      presc_q <= (presc_q == PRESC_TC) ? '0 : presc_q + PRESC_W'(1);
    end
  end
`else
  assign update = ena;
`endif

  logic [N-1:0] out_q;
  dir_state_t   dir_q;
  logic         cycle_done_q;
  wave_mode_t   mode_q;
  logic [N-1:0] phase_q;

  logic [N-1:0] out_d;
  dir_state_t   dir_d;
  logic         cycle_done_d;
  wave_mode_t   mode_d;
  logic [N-1:0] phase_d;

  // A zero step behaves like a step of one.
  logic [N-1:0] step_eff;
  assign step_eff = (step == '0) ? N'(1) : step;

  // Saw modes always step in their fixed direction; triangle follows the FSM.
  logic stepper_dir;
  always_comb begin
    case (mode_in)
      M_SAW_UP:   stepper_dir = 1'b1;
      M_SAW_DOWN: stepper_dir = 1'b0;
      default:    stepper_dir = dir_q;
    endcase
  end

  logic [N-1:0] stepped;
  logic         hit_bound;

  bounded_stepper #(.N(N)) u_stepper (
    .value      (out_q),
    .step       (step_eff),
    .lo         (lo),
    .hi         (hi),
    .direction  (stepper_dir),
    .next_value (stepped),
    .hit_bound  (hit_bound)
  );

  // Square phase: the level toggles once the current one has lasted step updates.
  logic [N:0] phase_inc;
  logic       phase_done;
  assign phase_inc  = {1'b0, phase_q} + {{N{1'b0}}, 1'b1};
  assign phase_done = phase_inc >= {1'b0, step_eff};

  // Next-state and next-output decode for one update; everything holds otherwise.
  always_comb begin
    out_d        = out_q;
    dir_d        = dir_q;
    mode_d       = mode_q;
    phase_d      = phase_q;
    cycle_done_d = 1'b0;
    if (update) begin
      if (lo >= hi) begin
        // Degenerate bounds: pin to lo, keep the direction.
        out_d = lo;
      end else if ((mode_in != mode_q) || (out_q < lo) || (out_q > hi)) begin
        // Mode switch or value outside the window: restart the mode.
        out_d   = (mode_in == M_SAW_DOWN) ? hi : lo;
        dir_d   = start_dir(mode_in);
        mode_d  = mode_in;
        phase_d = '0;
      end else begin
        case (mode_in)
          M_TRIANGLE: begin
            if (dir_q == S_UP) begin
              if (hit_bound || (stepped == hi)) begin
                out_d = hi;
                dir_d = S_DOWN;
              end else begin
                out_d = stepped;
              end
            end else begin
              if (hit_bound || (stepped == lo)) begin
                out_d        = lo;
                dir_d        = S_UP;
                cycle_done_d = 1'b1;
              end else begin
                out_d = stepped;
              end
            end
          end
          M_SAW_UP: begin
            if (hit_bound) begin
              out_d        = lo;
              cycle_done_d = 1'b1;
            end else begin
              out_d = stepped;
            end
          end
          M_SAW_DOWN: begin
            if (hit_bound) begin
              out_d        = hi;
              cycle_done_d = 1'b1;
            end else begin
              out_d = stepped;
            end
          end
          default: begin
            if (phase_done) begin
              phase_d = '0;
              if (out_q == hi) begin
                out_d = lo;
                dir_d = S_DOWN;
              end else begin
                out_d        = hi;
                dir_d        = S_UP;
                cycle_done_d = 1'b1;
              end
            end else begin
              phase_d = phase_inc[N-1:0];
            end
          end
        endcase
      end
    end
  end

  // State register for the waveform, direction FSM, mode and square phase.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      dir_q        <= S_UP;
      cycle_done_q <= 1'b0;
      mode_q       <= M_TRIANGLE;
      phase_q      <= '0;
    end else begin
      out_q        <= out_d;
      dir_q        <= dir_d;
      cycle_done_q <= cycle_done_d;
      mode_q       <= mode_d;
      phase_q      <= phase_d;
    end
  end

  assign out        = out_q;
  assign dir        = dir_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_waveform_generator.sv
// Self-checking bench for waveform_generator (default build, no prescaler).
module tb_waveform_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] mode;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [7:0] step;
  logic [7:0] out;
  logic       dir;
  logic       cycle_done;

  int passed = 0;
  int total  = 0;

  waveform_generator #(.N(8), .DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .mode       (mode),
    .lo         (lo),
    .hi         (hi),
    .step       (step),
    .out        (out),
    .dir        (dir),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       e;
    logic [1:0] m;
    logic [7:0] l;
    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] eo;
    logic       ed;
    logic       ec;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drive inputs, take one clock edge, settle 1 time unit past the edge.
  task automatic tick(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] l, input logic [7:0] h, input logic [7:0] s);
    rst = r; ena = e; mode = m; lo = l; hi = h; step = s;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [7:0] eo,
                              input logic ed, input logic ec);
    check({tag, ".out"}, int'(out), int'(eo));
    check({tag, ".dir"}, int'(dir), int'(ed));
    check({tag, ".cycle_done"}, int'(cycle_done), int'(ec));
  endtask

  initial begin
    int u;
    int pulses;
    logic e;
    logic [7:0] eo;
    logic ed, ec;

    //             r  e  m   lo   hi   st   out  dir cd
    vecs.push_back('{1, 1, 0, 10,  20,  4,   0,  1, 0}); // reset wins over ena
    vecs.push_back('{0, 1, 0, 10,  20,  4,  10,  1, 0}); // out below lo -> start
    vecs.push_back('{0, 1, 0, 10,  20,  4,  14,  1, 0});
    vecs.push_back('{0, 1, 0, 10,  20,  4,  18,  1, 0});
    vecs.push_back('{0, 1, 0, 10,  20,  4,  20,  0, 0}); // clamp at hi, turn
    vecs.push_back('{0, 1, 0, 10,  20,  4,  16,  0, 0});
    vecs.push_back('{0, 1, 0, 10,  20,  4,  12,  0, 0});
    vecs.push_back('{0, 1, 0, 10,  20,  4,  10,  1, 1}); // clamp at lo, pulse
    vecs.push_back('{0, 1, 0, 10,  20,  4,  14,  1, 0});
    vecs.push_back('{0, 0, 0, 10,  20,  4,  14,  1, 0}); // hold
    vecs.push_back('{0, 1, 1, 250, 255, 3, 250,  1, 0}); // mode change to saw up
    vecs.push_back('{0, 1, 1, 250, 255, 3, 253,  1, 0});
    vecs.push_back('{0, 1, 1, 250, 255, 3, 250,  1, 1}); // no mod-256 wrap
    vecs.push_back('{0, 1, 1, 250, 255, 3, 253,  1, 0});
    vecs.push_back('{0, 0, 1, 250, 255, 3, 253,  1, 0}); // hold, no pulse
    vecs.push_back('{0, 1, 1, 250, 255, 0, 254,  1, 0}); // step 0 acts as 1
    vecs.push_back('{0, 1, 1, 250, 255, 0, 255,  1, 0}); // lands on hi exactly
    vecs.push_back('{0, 1, 1, 250, 255, 0, 250,  1, 1});
    vecs.push_back('{0, 1, 1, 7,   7,   1,   7,  1, 0}); // lo == hi pins
    vecs.push_back('{0, 1, 1, 7,   7,   1,   7,  1, 0});
    vecs.push_back('{0, 1, 2, 0,   9,   4,   9,  0, 0}); // saw down start = hi
    vecs.push_back('{0, 1, 2, 0,   9,   4,   5,  0, 0});
    vecs.push_back('{0, 1, 2, 0,   9,   4,   1,  0, 0});
    vecs.push_back('{0, 1, 2, 0,   9,   4,   9,  0, 1}); // 1 < 0+4 -> hi
    vecs.push_back('{0, 1, 2, 8,   3,   4,   8,  0, 0}); // lo > hi, dir kept
    vecs.push_back('{0, 1, 2, 20,  30,  4,  30,  0, 0}); // out of range -> hi
    vecs.push_back('{0, 1, 2, 20,  30,  4,  26,  0, 0});
    vecs.push_back('{1, 1, 2, 20,  30,  4,   0,  1, 0}); // reset mid-waveform
    vecs.push_back('{0, 0, 0, 0,   255, 1,   0,  1, 0});
    vecs.push_back('{0, 1, 0, 10,  20,  5,  10,  1, 0});
    vecs.push_back('{0, 1, 0, 10,  20,  5,  15,  1, 0});
    vecs.push_back('{0, 1, 0, 10,  20,  5,  20,  0, 0}); // exact land on hi turns
    vecs.push_back('{0, 1, 0, 10,  20,  5,  15,  0, 0});
    vecs.push_back('{0, 1, 0, 10,  20,  5,  10,  1, 1}); // out == lo+step

    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    expect_state("reset", 8'd0, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      tick(vecs[i].r, vecs[i].e, vecs[i].m, vecs[i].l, vecs[i].h, vecs[i].s);
      expect_state($sformatf("vec%0d", i), vecs[i].eo, vecs[i].ed, vecs[i].ec);
    end

    // Full-range triangle: 0 -> 255 -> 0 over 510 updates, one pulse.
    tick(1, 1, 0, 0, 255, 1);
    pulses = 0;
    for (int k = 1; k <= 510; k++) begin
      tick(0, 1, 0, 0, 255, 1);
      eo = (k <= 255) ? 8'(k) : 8'(510 - k);
      ed = (k < 255) || (k == 510);
      ec = (k == 510);
      if (cycle_done) pulses++;
      expect_state($sformatf("tri_full%0d", k), eo, ed, ec);
    end
    check("tri_full.pulses", pulses, 1);

    // Square with ena every other clock: 3 updates (6 clocks) per level.
    tick(1, 0, 0, 0, 0, 0);
    u = 0;
    for (int c = 0; c < 36; c++) begin
      e = (c % 2 == 0);
      tick(0, e, 3, 5, 200, 3);
      if (e) u++;
      eo = (((u - 1) / 3) % 2 == 0) ? 8'd5 : 8'd200;
      ed = (eo == 8'd200) || (u <= 3);
      ec = e && ((u - 1) % 6 == 3);
      expect_state($sformatf("square%0d", c), eo, ed, ec);
    end

    // Mode switch mid-ramp: triangle -> saw down loads hi, no pulse.
    tick(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick(0, 1, 0, 0, 255, 1);
    expect_state("switch.ramp", 8'd5, 1'b1, 1'b0);
    tick(0, 1, 2, 0, 255, 1);
    expect_state("switch.load", 8'd255, 1'b0, 1'b0);
    tick(0, 1, 2, 0, 255, 1);
    expect_state("switch.next", 8'd254, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
